// File: rtl/pipe_hazard_ctrl_if.sv
// Stage-register fields into the hazard controller and the stall/flush/forward
// controls back to the 5-stage datapath.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [4:0]       ex_rd;
  logic             ex_reg_we;
  logic             ex_is_load;
  logic [4:0]       mem_rd;
  logic             mem_reg_we;
  logic [4:0]       wb_rd;
  logic             wb_reg_we;
  logic [4:0]       ex_rs1;
  logic [4:0]       ex_rs2;
  logic             ex_br_taken;
  logic             mem_req;
  logic             mem_ready;

  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             id_ex_stall;
  logic             ex_mem_stall;
  logic             mem_wb_bubble;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles;

  // Datapath side: supplies stage fields, consumes controls.
  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_reg_we, ex_is_load,
           mem_rd, mem_reg_we, wb_rd, wb_reg_we, ex_rs1, ex_rs2, ex_br_taken,
           mem_req, mem_ready,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_flush, id_ex_stall, ex_mem_stall,
           mem_wb_bubble, fwd_a_sel, fwd_b_sel, mem_err, stall_cycles
  );

  // Controller side.
  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_reg_we, ex_is_load,
           mem_rd, mem_reg_we, wb_rd, wb_reg_we, ex_rs1, ex_rs2, ex_br_taken,
           mem_req, mem_ready,
    output pc_stall, if_id_stall, if_id_flush, id_ex_flush, id_ex_stall, ex_mem_stall,
           mem_wb_bubble, fwd_a_sel, fwd_b_sel, mem_err, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer for the 5-stage core: stall/flush/bubble controls, EX operand
// forwarding selects, and a memory-wait watchdog that latches a sticky error.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  pipe_hazard_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic       mem_busy_s;
  logic       load_use_s;
  logic       timeout_hit_s;
  logic       pc_stall_s;
  logic       if_id_stall_s;
  logic       if_id_flush_s;
  logic       id_ex_flush_s;
  logic       id_ex_stall_s;
  logic       ex_mem_stall_s;
  logic       mem_wb_bubble_s;
  logic [1:0] fwd_a_sel_s;
  logic [1:0] fwd_b_sel_s;

  // Younger stage (MEM) wins over WB; x0 is hardwired zero so never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic [4:0] m_rd, input logic m_we,
                                         input logic [4:0] w_rd, input logic w_we);
    logic [1:0] sel;
    sel = 2'd0;
    if (src != 5'd0 && m_we && m_rd == src) begin
      sel = 2'd1;
    end else if (src != 5'd0 && w_we && w_rd == src) begin
      sel = 2'd2;
    end else begin
      sel = 2'd0;
    end
    return sel;
  endfunction

  assign mem_busy_s    = bus.mem_req & ~bus.mem_ready;
  assign timeout_hit_s = (wait_cnt_q == 16'(TIMEOUT - 1));
  assign load_use_s    = bus.ex_is_load & bus.ex_reg_we & (bus.ex_rd != 5'd0) &
                         ((bus.id_rs1_used & (bus.id_rs1 == bus.ex_rd)) |
                          (bus.id_rs2_used & (bus.id_rs2 == bus.ex_rd)));

  // Pipeline controls by priority: error > memory busy > taken branch > load-use.
  always_comb begin
    pc_stall_s      = 1'b0;
    if_id_stall_s   = 1'b0;
    if_id_flush_s   = 1'b0;
    id_ex_flush_s   = 1'b0;
    id_ex_stall_s   = 1'b0;
    ex_mem_stall_s  = 1'b0;
    mem_wb_bubble_s = 1'b0;
    fwd_a_sel_s     = 2'd0;
    fwd_b_sel_s     = 2'd0;
    if (rst) begin
      pc_stall_s = 1'b0;
    end else begin
      if (state_q == ST_ERR || mem_busy_s) begin
        pc_stall_s      = 1'b1;
        if_id_stall_s   = 1'b1;
        id_ex_stall_s   = 1'b1;
        ex_mem_stall_s  = 1'b1;
        mem_wb_bubble_s = 1'b1;
      end else if (bus.ex_br_taken) begin
        if_id_flush_s = 1'b1;
        id_ex_flush_s = 1'b1;
      end else if (load_use_s) begin
        pc_stall_s    = 1'b1;
        if_id_stall_s = 1'b1;
        id_ex_flush_s = 1'b1;
      end else begin
        pc_stall_s = 1'b0;
      end
      fwd_a_sel_s = fwd_sel(bus.ex_rs1, bus.mem_rd, bus.mem_reg_we, bus.wb_rd, bus.wb_reg_we);
      fwd_b_sel_s = fwd_sel(bus.ex_rs2, bus.mem_rd, bus.mem_reg_we, bus.wb_rd, bus.wb_reg_we);
    end
  end

  // Next state, wait watchdog, sticky error and saturating stall counter.
  always_comb begin
    state_d        = state_q;
    mem_err_d      = mem_err_q;
    stall_cycles_d = stall_cycles_q;
    if (mem_busy_s) begin
      wait_cnt_d = (wait_cnt_q == 16'hFFFF) ? wait_cnt_q : wait_cnt_q + 16'd1;
    end else begin
      wait_cnt_d = 16'd0;
    end
    case (state_q)
      ST_RUN, ST_MEM_WAIT: begin
        if (mem_busy_s && timeout_hit_s) begin
          state_d   = ST_ERR;
          mem_err_d = 1'b1;
        end else if (mem_busy_s) begin
          state_d = ST_MEM_WAIT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_ERR: begin
        state_d   = ST_ERR;
        mem_err_d = 1'b1;
      end
      // An unreachable encoding is treated as a fault: hold the pipe.
      default: begin
        state_d   = ST_ERR;
        mem_err_d = 1'b1;
      end
    endcase
    if (pc_stall_s && !(&stall_cycles_q)) begin
      stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // All controller state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_RUN;
      wait_cnt_q     <= 16'd0;
      mem_err_q      <= 1'b0;
      stall_cycles_q <= {CNT_W{1'b0}};
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_err_q      <= mem_err_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign bus.pc_stall      = pc_stall_s;
  assign bus.if_id_stall   = if_id_stall_s;
  assign bus.if_id_flush   = if_id_flush_s;
  assign bus.id_ex_flush   = id_ex_flush_s;
  assign bus.id_ex_stall   = id_ex_stall_s;
  assign bus.ex_mem_stall  = ex_mem_stall_s;
  assign bus.mem_wb_bubble = mem_wb_bubble_s;
  assign bus.fwd_a_sel     = fwd_a_sel_s;
  assign bus.fwd_b_sel     = fwd_b_sel_s;
  assign bus.mem_err       = mem_err_q;
  assign bus.stall_cycles  = stall_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard scenarios followed by
// random stage traffic, checked against a rule-level reference model.
module tb_pipe_hazard_ctrl;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 5;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic [4:0] ex_rd;
    logic       ex_reg_we;
    logic       ex_is_load;
    logic [4:0] mem_rd;
    logic       mem_reg_we;
    logic [4:0] wb_rd;
    logic       wb_reg_we;
    logic [4:0] ex_rs1;
    logic [4:0] ex_rs2;
    logic       ex_br_taken;
    logic       mem_req;
    logic       mem_ready;
  } stim_t;

  // ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_flush, id_ex_stall,
  //        ex_mem_stall, mem_wb_bubble, fwd_a_sel, fwd_b_sel, mem_err}
  typedef struct {
    logic [11:0] ctl;
    int          stalls;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference model: consecutive-busy run length, error flag, stall total.
  bit m_err      = 1'b0;
  int m_busy_len = 0;
  int m_stalls   = 0;

  function automatic logic [1:0] model_fwd(input logic [4:0] src, input stim_t s);
    if (src != 5'd0 && s.mem_reg_we && s.mem_rd == src) return 2'd1;
    if (src != 5'd0 && s.wb_reg_we && s.wb_rd == src) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [11:0] model_ctl(input stim_t s);
    logic busy, lu, hold, flush_br, lu_act;
    busy = s.mem_req && !s.mem_ready;
    lu = s.ex_is_load && s.ex_reg_we && s.ex_rd != 5'd0 &&
         ((s.id_rs1_used && s.id_rs1 == s.ex_rd) || (s.id_rs2_used && s.id_rs2 == s.ex_rd));
    hold     = m_err || busy;
    flush_br = !hold && s.ex_br_taken;
    lu_act   = !hold && !s.ex_br_taken && lu;
    return {hold || lu_act, hold || lu_act, flush_br, flush_br || lu_act,
            hold, hold, hold, model_fwd(s.ex_rs1, s), model_fwd(s.ex_rs2, s), m_err};
  endfunction

  task automatic apply(input stim_t s);
    bus.id_rs1      = s.id_rs1;      bus.id_rs2      = s.id_rs2;
    bus.id_rs1_used = s.id_rs1_used; bus.id_rs2_used = s.id_rs2_used;
    bus.ex_rd       = s.ex_rd;       bus.ex_reg_we   = s.ex_reg_we;
    bus.ex_is_load  = s.ex_is_load;  bus.mem_rd      = s.mem_rd;
    bus.mem_reg_we  = s.mem_reg_we;  bus.wb_rd       = s.wb_rd;
    bus.wb_reg_we   = s.wb_reg_we;   bus.ex_rs1      = s.ex_rs1;
    bus.ex_rs2      = s.ex_rs2;      bus.ex_br_taken = s.ex_br_taken;
    bus.mem_req     = s.mem_req;     bus.mem_ready   = s.mem_ready;
  endtask

  task automatic drive(input stim_t s, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply(s);
    e.ctl = model_ctl(s); e.stalls = m_stalls; e.tag = tag;
    exp_q.push_back(e);
    if (e.ctl[11] && m_stalls < CNT_MAX) m_stalls++;
    if (!m_err) begin
      if (s.mem_req && !s.mem_ready) begin
        m_busy_len++;
        if (m_busy_len >= TIMEOUT) m_err = 1'b1;
      end else begin
        m_busy_len = 0;
      end
    end
  endtask

  task automatic do_reset(input stim_t s, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst = 1'b1;
    apply(s);
    e.ctl = 12'd0; e.stalls = 0; e.tag = tag;
    exp_q.push_back(e);
    m_err = 1'b0; m_busy_len = 0; m_stalls = 0;
  endtask

  // Monitor: outputs are valid every cycle, so compare at each falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [11:0] got;
      e = exp_q.pop_front();
      got = {bus.pc_stall, bus.if_id_stall, bus.if_id_flush, bus.id_ex_flush, bus.id_ex_stall,
             bus.ex_mem_stall, bus.mem_wb_bubble, bus.fwd_a_sel, bus.fwd_b_sel, bus.mem_err};
      compared++;
      if (got !== e.ctl) begin
        mismatched++;
        $display("FAIL %s ctl: got %b expected %b", e.tag, got, e.ctl);
      end
      compared++;
      if (int'(bus.stall_cycles) != e.stalls) begin
        mismatched++;
        $display("FAIL %s stall_cycles: got %0d expected %0d", e.tag, bus.stall_cycles, e.stalls);
      end
    end
  end

  initial begin
    stim_t s;
    s = '0;
    apply(s);
    do_reset(s, "por");
    // T1: reset while waiting on memory
    s.mem_req = 1'b1;
    drive(s, "t1_wait0");
    drive(s, "t1_wait1");
    do_reset(s, "t1_rst");
    s = '0;
    drive(s, "t1_after");
    // T2: load-use, then forwarding from MEM, then x0 destination
    s = '0; s.ex_is_load = 1'b1; s.ex_reg_we = 1'b1; s.ex_rd = 5'd5;
    s.id_rs1 = 5'd5; s.id_rs1_used = 1'b1;
    drive(s, "t2_lu");
    s = '0; s.mem_rd = 5'd5; s.mem_reg_we = 1'b1; s.ex_rs1 = 5'd5;
    drive(s, "t2_fwd");
    s = '0; s.ex_is_load = 1'b1; s.ex_reg_we = 1'b1; s.ex_rd = 5'd0; s.id_rs1_used = 1'b1;
    drive(s, "t2_x0");
    // T3: forwarding priority
    s = '0; s.mem_rd = 5'd7; s.mem_reg_we = 1'b1; s.wb_rd = 5'd7; s.wb_reg_we = 1'b1;
    s.ex_rs2 = 5'd7;
    drive(s, "t3_mem");
    s.mem_reg_we = 1'b0;
    drive(s, "t3_wb");
    s.ex_rs2 = 5'd0;
    drive(s, "t3_x0");
    // T4: three wait cycles then ready
    s = '0; s.mem_req = 1'b1;
    for (int i = 0; i < 3; i++) drive(s, "t4_wait");
    s.mem_ready = 1'b1;
    drive(s, "t4_ready");
    s = '0;
    drive(s, "t4_idle");
    // T5: busy + branch + load-use, then ready
    s = '0; s.mem_req = 1'b1; s.ex_br_taken = 1'b1; s.ex_is_load = 1'b1; s.ex_reg_we = 1'b1;
    s.ex_rd = 5'd3; s.id_rs2 = 5'd3; s.id_rs2_used = 1'b1;
    drive(s, "t5_busy");
    s.mem_ready = 1'b1;
    drive(s, "t5_br");
    // T6: timeout into sticky error
    s = '0; s.mem_req = 1'b1;
    for (int i = 0; i < 6; i++) drive(s, "t6_wait");
    s.mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) drive(s, "t6_sticky");
    s = '0;
    do_reset(s, "t6_rst");
    drive(s, "t6_clear");
    // Random traffic with occasional resets
    for (int n = 0; n < 1500; n++) begin
      s.id_rs1      = 5'($urandom_range(0, 3)); s.id_rs2 = 5'($urandom_range(0, 3));
      s.id_rs1_used = 1'($urandom);             s.id_rs2_used = 1'($urandom);
      s.ex_rd       = 5'($urandom_range(0, 3)); s.ex_reg_we = 1'($urandom);
      s.ex_is_load  = 1'($urandom);             s.mem_rd = 5'($urandom_range(0, 3));
      s.mem_reg_we  = 1'($urandom);             s.wb_rd = 5'($urandom_range(0, 3));
      s.wb_reg_we   = 1'($urandom);             s.ex_rs1 = 5'($urandom_range(0, 3));
      s.ex_rs2      = 5'($urandom_range(0, 3)); s.ex_br_taken = ($urandom_range(0, 4) == 0);
      s.mem_req     = ($urandom_range(0, 9) < 4); s.mem_ready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 119) == 0) do_reset(s, "rnd_rst");
      else drive(s, "rnd");
    end
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    if (exp_q.size() > 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
